// File: rtl/cga_regfile_ext.sv
// ---------------------------------------------------------------------------
// cga_regfile_ext
//   CGA/Tandy I/O register file with an indexed Tandy register port, an
//   N-entry palette (shadow + active copies, auto-increment index), optional
//   vblank-deferred palette commit, synchronised status bits and a
//   memory-cycle wait-state generator.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   bus_a/bus_d         ISA address (15b) and write data (8b)
//   bus_ior_l/bus_iow_l I/O read/write strobes, active low (synchronised here)
//   bus_mem_cs          framebuffer memory cycle, drives the wait FSM
//   bus_aen             DMA address enable, blocks I/O decode when high
//   bus_out/bus_dir     read data and read-drive enable
//   bus_rdy             ISA ready
//   vsync/vblank/display_enable  CRTC timing inputs
//   control_reg/color_reg/tandy_mode/pal_mask  register outputs
//   pal_rd_idx/pal_rd_data  pixel-side palette lookup (1 clk latency)
//   pal_committed       1-clk pulse when palette data reaches the active copy
//
// Wait FSM
//   state   | meaning
//   IDLE    | no memory cycle in progress, rdy=1
//   WAIT    | memory cycle started, rdy=0 while counting down
//   DONE    | wait served, rdy=1 until bus_mem_cs drops
// ---------------------------------------------------------------------------
module cga_regfile_ext #(
   parameter logic [15:0] IO_BASE_ADDR    = 16'h3D0,
   parameter int          PAL_ENTRIES     = 16,
   parameter int          PAL_WIDTH       = 4,
   parameter int          WAIT_CYCLES     = 4,
   parameter int          SYNC_STAGES     = 2,
   parameter int          DEFER_TO_VBLANK = 1,
   localparam int         IDX_W           = $clog2(PAL_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [14:0]          bus_a,
   input  logic                 bus_ior_l,
   input  logic                 bus_iow_l,
   input  logic                 bus_mem_cs,
   input  logic                 bus_aen,
   input  logic [7:0]           bus_d,
   output logic [7:0]           bus_out,
   output logic                 bus_dir,
   output logic                 bus_rdy,
   input  logic                 vsync,
   input  logic                 vblank,
   input  logic                 display_enable,
   output logic [7:0]           control_reg,
   output logic [7:0]           color_reg,
   output logic [7:0]           tandy_mode,
   output logic [PAL_WIDTH-1:0] pal_mask,
   input  logic [IDX_W-1:0]     pal_rd_idx,
   output logic [PAL_WIDTH-1:0] pal_rd_data,
   output logic                 pal_committed
);

   localparam logic [14:0] A_CTRL  = IO_BASE_ADDR[14:0] + 15'h8;
   localparam logic [14:0] A_COLOR = IO_BASE_ADDR[14:0] + 15'h9;
   localparam logic [14:0] A_STAT  = IO_BASE_ADDR[14:0] + 15'hA;
   localparam logic [14:0] A_DATA  = IO_BASE_ADDR[14:0] + 15'hE;
   localparam logic [5:0]  PAL_END = 6'(16 + PAL_ENTRIES);

   // synchronisers
   logic [SYNC_STAGES-1:0] ior_sr, iow_sr, vs_sr, de_sr;
   logic ior_q, iow_q;
   logic ior_s, iow_s, vs_s, de_s;

   assign ior_s = ior_sr[SYNC_STAGES-1];
   assign iow_s = iow_sr[SYNC_STAGES-1];
   assign vs_s  = vs_sr[SYNC_STAGES-1];
   assign de_s  = de_sr[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         ior_sr <= '1;
         iow_sr <= '1;
         vs_sr  <= '0;
         de_sr  <= '0;
         ior_q  <= 1'b1;
         iow_q  <= 1'b1;
      end else begin
         ior_sr <= {ior_sr[SYNC_STAGES-2:0], bus_ior_l};
         iow_sr <= {iow_sr[SYNC_STAGES-2:0], bus_iow_l};
         vs_sr  <= {vs_sr[SYNC_STAGES-2:0], vsync};
         de_sr  <= {de_sr[SYNC_STAGES-2:0], display_enable};
         ior_q  <= ior_s;
         iow_q  <= iow_s;
      end
   end

   // one action per strobe: only the synced falling edge fires
   logic rd_fire, wr_fire;
   assign rd_fire = ior_q & ~ior_s;
   assign wr_fire = iow_q & ~iow_s;

   logic cs_ctrl, cs_color, cs_stat, cs_data;
   assign cs_ctrl  = (bus_a == A_CTRL)  & ~bus_aen;
   assign cs_color = (bus_a == A_COLOR) & ~bus_aen;
   assign cs_stat  = (bus_a == A_STAT)  & ~bus_aen;
   assign cs_data  = (bus_a == A_DATA)  & ~bus_aen;

   // status is the only readable location
   assign bus_dir = cs_stat & ~bus_ior_l;
   assign bus_out = bus_dir ? {4'b1111, vs_s, 2'b10, ~de_s} : 8'h00;

   logic [4:0]           tandy_idx;
   logic [PAL_WIDTH-1:0] shadow [PAL_ENTRIES];
   logic [PAL_WIDTH-1:0] active [PAL_ENTRIES];
   logic                 pending;
   logic                 vblank_q;

   logic             idx_is_pal;
   logic [IDX_W-1:0] pal_sel;
   logic [IDX_W-1:0] pal_next;
   logic             shadow_wr;
   logic             vb_rise;
   logic             commit_all;

   assign idx_is_pal = tandy_idx[4] & ({1'b0, tandy_idx} < PAL_END);
   assign pal_sel    = tandy_idx[IDX_W-1:0];
   assign pal_next   = pal_sel + IDX_W'(1);
   assign shadow_wr  = wr_fire & cs_data & idx_is_pal;
   assign vb_rise    = vblank & ~vblank_q;
   assign commit_all = (DEFER_TO_VBLANK != 0) & vb_rise & pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         control_reg   <= 8'h29;
         color_reg     <= 8'h00;
         tandy_mode    <= 8'h00;
         pal_mask      <= '1;
         tandy_idx     <= 5'h00;
         pending       <= 1'b0;
         vblank_q      <= 1'b0;
         pal_rd_data   <= '0;
         pal_committed <= 1'b0;
         for (int i = 0; i < PAL_ENTRIES; i++) begin
            shadow[i] <= PAL_WIDTH'(i);
            active[i] <= PAL_WIDTH'(i);
         end
      end else begin
         vblank_q    <= vblank;
         pal_rd_data <= active[pal_rd_idx];

         if (wr_fire) begin
            if (cs_ctrl)  control_reg <= bus_d;
            if (cs_color) color_reg   <= bus_d;
            if (cs_stat)  tandy_idx   <= bus_d[4:0];
            if (cs_data) begin
               if (tandy_idx == 5'h01) begin
                  pal_mask <= bus_d[PAL_WIDTH-1:0];
               end else if (tandy_idx == 5'h03) begin
                  tandy_mode <= bus_d;
               end else if (idx_is_pal) begin
                  shadow[pal_sel] <= bus_d[PAL_WIDTH-1:0];
                  // palette range is 0x10-aligned, so the low bits wrap on their own
                  tandy_idx <= 5'h10 | 5'(pal_next);
               end
            end
         end

         // a status read resets the index flip-flop
         if (rd_fire && cs_stat) tandy_idx <= 5'h00;

         if (DEFER_TO_VBLANK != 0) begin
            // commit copies the pre-write shadow; a coincident write stays pending
            if (commit_all) begin
               for (int i = 0; i < PAL_ENTRIES; i++) active[i] <= shadow[i];
            end
            if (shadow_wr)       pending <= 1'b1;
            else if (commit_all) pending <= 1'b0;
            pal_committed <= commit_all;
         end else begin
            if (shadow_wr) active[pal_sel] <= bus_d[PAL_WIDTH-1:0];
            pal_committed <= shadow_wr;
         end
      end
   end

   generate
      if (WAIT_CYCLES == 0) begin : g_no_wait
         assign bus_rdy = 1'b1;
      end else begin : g_wait
         localparam int CW = $clog2(WAIT_CYCLES + 1);
         typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} wait_state_t;

         wait_state_t   state;
         logic [CW-1:0] cnt;
         logic          mem_cs_q;
         logic          rdy_r;

         always_ff @(posedge clk) begin
            if (reset) begin
               state    <= ST_IDLE;
               cnt      <= '0;
               mem_cs_q <= 1'b0;
               rdy_r    <= 1'b1;
            end else begin
               mem_cs_q <= bus_mem_cs;
               case (state)
                  ST_IDLE: begin
                     if (bus_mem_cs && !mem_cs_q) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(WAIT_CYCLES - 1);
                        rdy_r <= 1'b0;
                     end
                  end
                  ST_WAIT: begin
                     if (!bus_mem_cs) begin
                        state <= ST_IDLE;
                        rdy_r <= 1'b1;
                     end else if (cnt == '0) begin
                        state <= ST_DONE;
                        rdy_r <= 1'b1;
                     end else begin
                        cnt <= cnt - CW'(1);
                     end
                  end
                  ST_DONE: begin
                     if (!bus_mem_cs) state <= ST_IDLE;
                  end
                  default: begin
                     state <= ST_IDLE;
                     rdy_r <= 1'b1;
                  end
               endcase
            end
         end

         assign bus_rdy = rdy_r;
      end
   endgenerate

endmodule

// File: tb/tb_cga_regfile_ext.sv
// ---------------------------------------------------------------------------
// tb_cga_regfile_ext
//   Two instances share all inputs: dut (palette commit deferred to vblank)
//   and dut0 (immediate commit). Expected values are queued when stimulus is
//   driven and popped when the observed outputs are collected.
// ---------------------------------------------------------------------------
module tb_cga_regfile_ext;

   localparam int SYNC = 2;
   localparam logic [14:0] A_CTRL  = 15'h3D8;
   localparam logic [14:0] A_COLOR = 15'h3D9;
   localparam logic [14:0] A_STAT  = 15'h3DA;
   localparam logic [14:0] A_DATA  = 15'h3DE;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] bus_a;
   logic        bus_ior_l, bus_iow_l, bus_mem_cs, bus_aen;
   logic [7:0]  bus_d;
   logic        vsync, vblank, display_enable;
   logic [3:0]  pal_rd_idx;

   logic [7:0]  d1_out, d1_ctrl, d1_color, d1_tandy;
   logic        d1_dir, d1_rdy, d1_commit;
   logic [3:0]  d1_mask, d1_pal;
   logic [7:0]  d0_out, d0_ctrl, d0_color, d0_tandy;
   logic        d0_dir, d0_rdy, d0_commit;
   logic [3:0]  d0_mask, d0_pal;

   int total = 0;
   int bad   = 0;
   int commit1_cnt = 0;
   int commit0_cnt = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (d1_commit === 1'b1) commit1_cnt++;
      if (d0_commit === 1'b1) commit0_cnt++;
   end

   cga_regfile_ext dut (
      .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
      .bus_mem_cs(bus_mem_cs), .bus_aen(bus_aen), .bus_d(bus_d), .bus_out(d1_out),
      .bus_dir(d1_dir), .bus_rdy(d1_rdy), .vsync(vsync), .vblank(vblank),
      .display_enable(display_enable), .control_reg(d1_ctrl), .color_reg(d1_color),
      .tandy_mode(d1_tandy), .pal_mask(d1_mask), .pal_rd_idx(pal_rd_idx),
      .pal_rd_data(d1_pal), .pal_committed(d1_commit)
   );

   cga_regfile_ext #(.DEFER_TO_VBLANK(0)) dut0 (
      .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
      .bus_mem_cs(bus_mem_cs), .bus_aen(bus_aen), .bus_d(bus_d), .bus_out(d0_out),
      .bus_dir(d0_dir), .bus_rdy(d0_rdy), .vsync(vsync), .vblank(vblank),
      .display_enable(display_enable), .control_reg(d0_ctrl), .color_reg(d0_color),
      .tandy_mode(d0_tandy), .pal_mask(d0_mask), .pal_rd_idx(pal_rd_idx),
      .pal_rd_data(d0_pal), .pal_committed(d0_commit)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // write completes on the (SYNC+1)th edge after the strobe falls; vb_same
   // raises vblank so its rising edge lands on that same clock
   task automatic io_write(input logic [14:0] a, input logic [7:0] d, input bit vb_same = 1'b0);
      bus_a = a;
      bus_d = d;
      bus_iow_l = 1'b0;
      tick(SYNC);
      if (vb_same) vblank = 1'b1;
      tick(3);
      bus_iow_l = 1'b1;
      tick(SYNC + 2);
   endtask

   task automatic io_status_read();
      bus_a = A_STAT;
      bus_ior_l = 1'b0;
      tick(SYNC + 3);
      bus_ior_l = 1'b1;
      tick(SYNC + 2);
   endtask

   task automatic vblank_pulse();
      vblank = 1'b1;
      tick(2);
      vblank = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      logic [7:0] got[$];
      string      nm[$];
      logic [7:0] e;
      reset = 1'b1;
      pal_rd_idx = 4'd5;
      tick(3);
      exp_q.push_back(8'h29); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back(8'h0F); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      got.push_back(d1_ctrl);           nm.push_back("rst_control");
      got.push_back(d1_color);          nm.push_back("rst_color");
      got.push_back(d1_tandy);          nm.push_back("rst_tandy");
      got.push_back({4'h0, d1_mask});   nm.push_back("rst_mask");
      got.push_back({7'h0, d1_rdy});    nm.push_back("rst_rdy");
      got.push_back({7'h0, d1_commit}); nm.push_back("rst_commit");
      got.push_back({4'h0, d1_pal});    nm.push_back("rst_pal_data");
      reset = 1'b0;
      vsync = 1'b1;
      display_enable = 1'b0;
      tick(SYNC + 1);
      exp_q.push_back(8'h05); exp_q.push_back(8'h05);
      got.push_back({4'h0, d1_pal}); nm.push_back("identity5_defer");
      got.push_back({4'h0, d0_pal}); nm.push_back("identity5_imm");
      exp_q.push_back(8'hFD); exp_q.push_back(8'h01);
      bus_a = A_STAT;
      bus_ior_l = 1'b0;
      #1;
      got.push_back(d1_out);         nm.push_back("status_vs1_de0");
      got.push_back({7'h0, d1_dir}); nm.push_back("status_dir");
      tick(SYNC + 3);
      bus_ior_l = 1'b1;
      vsync = 1'b0;
      display_enable = 1'b1;
      tick(SYNC + 2);
      exp_q.push_back(8'hF4);
      bus_ior_l = 1'b0;
      #1;
      got.push_back(d1_out); nm.push_back("status_vs0_de1");
      tick(SYNC + 3);
      bus_ior_l = 1'b1;
      tick(SYNC + 2);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      bus_a = A_CTRL;
      bus_ior_l = 1'b0;
      #1;
      got.push_back(d1_out);         nm.push_back("ctrl_read_data");
      got.push_back({7'h0, d1_dir}); nm.push_back("ctrl_read_dir");
      tick(SYNC + 3);
      bus_ior_l = 1'b1;
      tick(SYNC + 2);
      foreach (got[i]) begin
         e = exp_q.pop_front();
         total++;
         if (got[i] !== e) begin bad++; $display("FAIL %s: got %h want %h", nm[i], got[i], e); end
      end
   endtask

   task automatic test_palette_immediate();
      logic [7:0] got[$];
      string      nm[$];
      logic [7:0] e;
      int c0, c1;
      io_write(A_STAT, 8'h10);
      c0 = commit0_cnt;
      c1 = commit1_cnt;
      io_write(A_DATA, 8'h03);
      io_write(A_DATA, 8'h07);
      exp_q.push_back(8'd2); exp_q.push_back(8'd0);
      got.push_back(8'(commit0_cnt - c0)); nm.push_back("imm_commit_pulses");
      got.push_back(8'(commit1_cnt - c1)); nm.push_back("defer_no_pulse");
      exp_q.push_back(8'h03); exp_q.push_back(8'h07); exp_q.push_back(8'h00);
      pal_rd_idx = 4'd0; tick(1);
      got.push_back({4'h0, d0_pal}); nm.push_back("imm_entry0");
      pal_rd_idx = 4'd1; tick(1);
      got.push_back({4'h0, d0_pal}); nm.push_back("imm_entry1");
      pal_rd_idx = 4'd0; tick(1);
      got.push_back({4'h0, d1_pal}); nm.push_back("defer_entry0_held");
      io_write(A_DATA, 8'h0C);
      exp_q.push_back(8'h0C);
      pal_rd_idx = 4'd2; tick(1);
      got.push_back({4'h0, d0_pal}); nm.push_back("imm_entry2_idx12");
      foreach (got[i]) begin
         e = exp_q.pop_front();
         total++;
         if (got[i] !== e) begin bad++; $display("FAIL %s: got %h want %h", nm[i], got[i], e); end
      end
   endtask

   task automatic test_vblank_commit();
      logic [7:0] got[$];
      string      nm[$];
      logic [7:0] e;
      int c1;
      c1 = commit1_cnt;
      vblank_pulse();
      exp_q.push_back(8'd1); exp_q.push_back(8'h03); exp_q.push_back(8'h07); exp_q.push_back(8'h0C);
      got.push_back(8'(commit1_cnt - c1)); nm.push_back("vb1_pulses");
      pal_rd_idx = 4'd0; tick(1); got.push_back({4'h0, d1_pal}); nm.push_back("vb1_entry0");
      pal_rd_idx = 4'd1; tick(1); got.push_back({4'h0, d1_pal}); nm.push_back("vb1_entry1");
      pal_rd_idx = 4'd2; tick(1); got.push_back({4'h0, d1_pal}); nm.push_back("vb1_entry2");
      io_write(A_STAT, 8'h1F);
      io_write(A_DATA, 8'h0A);
      io_write(A_DATA, 8'h0B);
      exp_q.push_back(8'h0F); exp_q.push_back(8'h03); exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
      pal_rd_idx = 4'd15; tick(1);
      got.push_back({4'h0, d1_pal}); nm.push_back("wrap_defer15_old");
      pal_rd_idx = 4'd0; tick(1);
      got.push_back({4'h0, d1_pal}); nm.push_back("wrap_defer0_old");
      pal_rd_idx = 4'd15; tick(1);
      got.push_back({4'h0, d0_pal}); nm.push_back("wrap_imm15");
      pal_rd_idx = 4'd0; tick(1);
      got.push_back({4'h0, d0_pal}); nm.push_back("wrap_imm0");
      c1 = commit1_cnt;
      vblank_pulse();
      exp_q.push_back(8'd1); exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
      got.push_back(8'(commit1_cnt - c1)); nm.push_back("vb2_pulses");
      pal_rd_idx = 4'd15; tick(1); got.push_back({4'h0, d1_pal}); nm.push_back("vb2_entry15");
      pal_rd_idx = 4'd0;  tick(1); got.push_back({4'h0, d1_pal}); nm.push_back("vb2_entry0");
      // write to entry 2 on the same clock as the vblank edge
      io_write(A_DATA, 8'h06);
      c1 = commit1_cnt;
      io_write(A_DATA, 8'h05, 1'b1);
      vblank = 1'b0;
      tick(2);
      exp_q.push_back(8'd1); exp_q.push_back(8'h06); exp_q.push_back(8'h0C);
      got.push_back(8'(commit1_cnt - c1)); nm.push_back("same_clk_pulses");
      pal_rd_idx = 4'd1; tick(1); got.push_back({4'h0, d1_pal}); nm.push_back("same_clk_entry1");
      pal_rd_idx = 4'd2; tick(1); got.push_back({4'h0, d1_pal}); nm.push_back("same_clk_entry2");
      c1 = commit1_cnt;
      vblank_pulse();
      exp_q.push_back(8'd1); exp_q.push_back(8'h05);
      got.push_back(8'(commit1_cnt - c1)); nm.push_back("next_frame_pulses");
      pal_rd_idx = 4'd2; tick(1); got.push_back({4'h0, d1_pal}); nm.push_back("next_frame_entry2");
      c1 = commit1_cnt;
      vblank_pulse();
      exp_q.push_back(8'd0);
      got.push_back(8'(commit1_cnt - c1)); nm.push_back("idle_vblank_pulses");
      foreach (got[i]) begin
         e = exp_q.pop_front();
         total++;
         if (got[i] !== e) begin bad++; $display("FAIL %s: got %h want %h", nm[i], got[i], e); end
      end
   endtask

   task automatic test_held_strobe();
      logic [7:0] got[$];
      string      nm[$];
      logic [7:0] e;
      bus_a = A_CTRL;
      bus_d = 8'h0A;
      bus_iow_l = 1'b0;
      exp_q.push_back(8'h0A);
      tick(6);
      bus_d = 8'h33;
      tick(14);
      bus_iow_l = 1'b1;
      tick(SYNC + 2);
      got.push_back(d1_ctrl); nm.push_back("held_write_once");
      bus_aen = 1'b1;
      exp_q.push_back(8'h0A);
      io_write(A_CTRL, 8'h44);
      bus_aen = 1'b0;
      got.push_back(d1_ctrl); nm.push_back("aen_blocks_write");
      exp_q.push_back(8'h15);
      io_write(A_COLOR, 8'h15);
      got.push_back(d1_color); nm.push_back("color_write");
      foreach (got[i]) begin
         e = exp_q.pop_front();
         total++;
         if (got[i] !== e) begin bad++; $display("FAIL %s: got %h want %h", nm[i], got[i], e); end
      end
   endtask

   task automatic test_tandy_regs();
      logic [7:0] got[$];
      string      nm[$];
      logic [7:0] e;
      io_write(A_STAT, 8'h01);
      exp_q.push_back(8'h07);
      io_write(A_DATA, 8'hA7);
      got.push_back({4'h0, d1_mask}); nm.push_back("pal_mask_write");
      io_write(A_STAT, 8'h03);
      exp_q.push_back(8'h5A);
      io_write(A_DATA, 8'h5A);
      got.push_back(d1_tandy); nm.push_back("tandy_mode_write");
      foreach (got[i]) begin
         e = exp_q.pop_front();
         total++;
         if (got[i] !== e) begin bad++; $display("FAIL %s: got %h want %h", nm[i], got[i], e); end
      end
   endtask

   task automatic test_bad_index();
      logic [7:0] got[$];
      string      nm[$];
      logic [7:0] e;
      int c0;
      io_write(A_STAT, 8'h07);
      c0 = commit0_cnt;
      exp_q.push_back(8'h0A); exp_q.push_back(8'h15); exp_q.push_back(8'h5A);
      exp_q.push_back(8'h07); exp_q.push_back(8'd0);
      io_write(A_DATA, 8'h55);
      got.push_back(d1_ctrl);              nm.push_back("bad_idx_control");
      got.push_back(d1_color);             nm.push_back("bad_idx_color");
      got.push_back(d1_tandy);             nm.push_back("bad_idx_tandy");
      got.push_back({4'h0, d1_mask});      nm.push_back("bad_idx_mask");
      got.push_back(8'(commit0_cnt - c0)); nm.push_back("bad_idx_commit");
      io_write(A_STAT, 8'h03);
      io_status_read();
      exp_q.push_back(8'h5A);
      io_write(A_DATA, 8'h66);
      got.push_back(d1_tandy); nm.push_back("status_read_clears_idx3");
      io_write(A_STAT, 8'h10);
      io_status_read();
      exp_q.push_back(8'h0B);
      io_write(A_DATA, 8'h09);
      pal_rd_idx = 4'd0; tick(1);
      got.push_back({4'h0, d0_pal}); nm.push_back("status_read_clears_idx10");
      foreach (got[i]) begin
         e = exp_q.pop_front();
         total++;
         if (got[i] !== e) begin bad++; $display("FAIL %s: got %h want %h", nm[i], got[i], e); end
      end
   endtask

   task automatic test_wait();
      logic [7:0] got[$];
      string      nm[$];
      logic [7:0] e;
      int lows;
      lows = 0;
      exp_q.push_back(8'd4); exp_q.push_back(8'h01);
      bus_mem_cs = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (d1_rdy !== 1'b1) lows++;
      end
      bus_mem_cs = 1'b0;
      tick(2);
      got.push_back(8'(lows));       nm.push_back("rdy_low_clks");
      got.push_back({7'h0, d1_rdy}); nm.push_back("rdy_after_cycle");
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      bus_mem_cs = 1'b1;
      tick(2);
      got.push_back({7'h0, d1_rdy}); nm.push_back("rdy_in_wait");
      bus_mem_cs = 1'b0;
      tick(1);
      got.push_back({7'h0, d1_rdy}); nm.push_back("rdy_abort_wait");
      tick(2);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h29);
      bus_mem_cs = 1'b1;
      tick(2);
      got.push_back({7'h0, d1_rdy}); nm.push_back("rdy_before_reset");
      reset = 1'b1;
      tick(1);
      got.push_back({7'h0, d1_rdy}); nm.push_back("rdy_reset_mid_wait");
      got.push_back(d1_ctrl);        nm.push_back("control_after_reset");
      reset = 1'b0;
      bus_mem_cs = 1'b0;
      tick(2);
      foreach (got[i]) begin
         e = exp_q.pop_front();
         total++;
         if (got[i] !== e) begin bad++; $display("FAIL %s: got %h want %h", nm[i], got[i], e); end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus_a = 15'h0;
      bus_ior_l = 1'b1;
      bus_iow_l = 1'b1;
      bus_mem_cs = 1'b0;
      bus_aen = 1'b0;
      bus_d = 8'h00;
      vsync = 1'b0;
      vblank = 1'b0;
      display_enable = 1'b0;
      pal_rd_idx = 4'd0;
      test_reset();
      test_palette_immediate();
      test_vblank_commit();
      test_held_strobe();
      test_tandy_regs();
      test_bad_index();
      test_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
